rx_logic: RTL and testbench

- Receive-side counterpart of the router output-port transmit logic.
- Accepts items from the five link directions (north, south, east, west, local) using the same ena/busy handshake the transmitters drive.
- Buffers one item per direction and merges them round-robin into the input FIFO of the router node.
- Sits between the incoming links and the node FIFO write port.

---
 rtl/rx_logic.sv | 104 ++++++++++
 tb/tb_rx_logic.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rx_logic.sv
// Receive side of a router port: one holding slot per link direction, drained
// round-robin into the node input FIFO using the same ena/busy handshake as the transmitters.
`ifndef SIZE
`define SIZE 8
`endif

module rx_logic #(
   parameter int SIZE = `SIZE
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            n_ena,
   input  logic [SIZE-1:0] n_item,
   output logic            n_busy,
   input  logic            s_ena,
   input  logic [SIZE-1:0] s_item,
   output logic            s_busy,
   input  logic            e_ena,
   input  logic [SIZE-1:0] e_item,
   output logic            e_busy,
   input  logic            w_ena,
   input  logic [SIZE-1:0] w_item,
   output logic            w_busy,
   input  logic            l_ena,
   input  logic [SIZE-1:0] l_item,
   output logic            l_busy,
   input  logic            full,
   output logic            write,
   output logic [SIZE-1:0] item_out
);

   localparam logic [2:0] DIR_LAST = 3'd4;

   logic [SIZE-1:0] slot    [5];
   logic [SIZE-1:0] item_in [5];
   logic [4:0]      valid;
   logic [4:0]      ena;
   logic [2:0]      rr_ptr;
   logic [2:0]      grant;
   logic            found;
   logic [3:0]      cand;

   // Direction index order: N=0, S=1, E=2, W=3, L=4.
   assign ena        = {l_ena, w_ena, e_ena, s_ena, n_ena};
   assign item_in[0] = n_item;
   assign item_in[1] = s_item;
   assign item_in[2] = e_item;
   assign item_in[3] = w_item;
   assign item_in[4] = l_item;

   assign n_busy = valid[0] | reset;
   assign s_busy = valid[1] | reset;
   assign e_busy = valid[2] | reset;
   assign w_busy = valid[3] | reset;
   assign l_busy = valid[4] | reset;

   // First valid slot at or after rr_ptr, walking cyclically through the five directions.
   always_comb begin
      grant = rr_ptr;
      found = 1'b0;
      cand  = 4'd0;
      for (int i = 0; i < 5; i++) begin
         cand = {1'b0, rr_ptr} + 4'(i);
         if (cand >= 4'd5) begin
            cand = cand - 4'd5;
         end
         if (!found && valid[cand[2:0]]) begin
            found = 1'b1;
            grant = cand[2:0];
         end
      end
   end

   assign write    = found & ~full & ~reset;
   assign item_out = slot[grant];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= '0;
         rr_ptr <= 3'd0;
      end else begin
         for (int d = 0; d < 5; d++) begin
            if (write && grant == 3'(d)) begin
               valid[d] <= 1'b0;
            end else if (ena[d] && !valid[d]) begin
               valid[d] <= 1'b1;
            end
         end
         if (write) begin
            rr_ptr <= (grant == DIR_LAST) ? 3'd0 : grant + 3'd1;
         end
      end
   end

   // Slot data needs no reset; a strobe into an occupied slot leaves it untouched.
   always_ff @(posedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (ena[d] && !valid[d]) begin
            slot[d] <= item_in[d];
         end
      end
   end

endmodule

// File: tb/tb_rx_logic.sv
// Testbench for rx_logic: per-cycle vector table for the basic handshake plus
// scoreboarded sequences for round-robin resume, backpressure and mid-run reset.
`ifndef SIZE
`define SIZE 8
`endif

module tb_rx_logic;

   localparam int SZ = `SIZE;

   typedef logic [4:0][SZ-1:0] items_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       full;
      logic [4:0] ena;
      items_t     items;
      logic       exp_write;
      logic [SZ-1:0] exp_item;
      logic [4:0] exp_busy;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          n_ena, s_ena, e_ena, w_ena, l_ena;
   logic [SZ-1:0] n_item, s_item, e_item, w_item, l_item;
   logic          n_busy, s_busy, e_busy, w_busy, l_busy;
   logic          full;
   logic          write;
   logic [SZ-1:0] item_out;
   logic [4:0]    busy_vec;

   int            compared   = 0;
   int            mismatched = 0;
   bit            sb_on      = 1'b0;
   logic [SZ-1:0] sbq[$];
   vec_t          vecs[$];

   rx_logic #(.SIZE(`SIZE)) dut (
      .clk(clk), .reset(reset),
      .n_ena(n_ena), .n_item(n_item), .n_busy(n_busy),
      .s_ena(s_ena), .s_item(s_item), .s_busy(s_busy),
      .e_ena(e_ena), .e_item(e_item), .e_busy(e_busy),
      .w_ena(w_ena), .w_item(w_item), .w_busy(w_busy),
      .l_ena(l_ena), .l_item(l_item), .l_busy(l_busy),
      .full(full), .write(write), .item_out(item_out)
   );

   assign busy_vec = {l_busy, w_busy, e_busy, s_busy, n_busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic items_t mk(input logic [SZ-1:0] n, s, e, w, l);
      items_t it;
      it[0] = n; it[1] = s; it[2] = e; it[3] = w; it[4] = l;
      return it;
   endfunction

   function automatic vec_t mkv(input string name, input logic r, f, input logic [4:0] e,
                                input items_t it, input logic ew, input logic [SZ-1:0] ei,
                                input logic [4:0] eb);
      vec_t v;
      v.name = name; v.rst = r; v.full = f; v.ena = e; v.items = it;
      v.exp_write = ew; v.exp_item = ei; v.exp_busy = eb;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic f, input logic [4:0] e, input items_t it);
      reset  = r;
      full   = f;
      n_ena  = e[0]; s_ena = e[1]; e_ena = e[2]; w_ena = e[3]; l_ena = e[4];
      n_item = it[0]; s_item = it[1]; e_item = it[2]; w_item = it[3]; l_item = it[4];
   endtask

   task automatic checkOutput(input string name, input logic ew, input logic [SZ-1:0] ei,
                              input logic [4:0] eb, input bit chk_item);
      @(negedge clk);
      compared++;
      if (write !== ew) begin
         mismatched++;
         $display("[TB] FAIL %s write: got %b want %b", name, write, ew);
      end
      if (chk_item && ew) begin
         compared++;
         if (item_out !== ei) begin
            mismatched++;
            $display("[TB] FAIL %s item_out: got %h want %h", name, item_out, ei);
         end
      end
      compared++;
      if (busy_vec !== eb) begin
         mismatched++;
         $display("[TB] FAIL %s busy(LWESN): got %b want %b", name, busy_vec, eb);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string name, input logic r, input logic f, input logic [4:0] e,
                       input items_t it, input logic ew, input logic [4:0] eb);
      applyStimulus(r, f, e, it);
      checkOutput(name, ew, '0, eb, 1'b0);
   endtask

   // Every FIFO write during scoreboarded sequences must match the next expected item.
   always @(negedge clk) begin
      if (sb_on && write === 1'b1) begin
         compared++;
         if (sbq.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL sb_write: got item %h want no write", item_out);
         end else begin
            logic [SZ-1:0] exp;
            exp = sbq.pop_front();
            if (item_out !== exp) begin
               mismatched++;
               $display("[TB] FAIL sb_item: got %h want %h", item_out, exp);
            end
         end
      end
   end

   initial begin
      items_t z;
      z = '0;
      applyStimulus(1'b1, 1'b0, 5'b0, z);

      vecs.push_back(mkv("rst0",    1, 0, 5'($urandom), mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55), 0, 8'h00, 5'b11111));
      vecs.push_back(mkv("rst1",    1, 0, 5'b11111,     mk(8'h66, 8'h77, 8'h88, 8'h99, 8'hAA), 0, 8'h00, 5'b11111));
      vecs.push_back(mkv("idle0",   0, 0, 5'b00000, z, 0, 8'h00, 5'b00000));
      vecs.push_back(mkv("idle1",   0, 0, 5'b00000, z, 0, 8'h00, 5'b00000));
      vecs.push_back(mkv("n_strobe",0, 0, 5'b00001, mk(8'hA5, 0, 0, 0, 0), 0, 8'h00, 5'b00000));
      vecs.push_back(mkv("n_write", 0, 0, 5'b00000, z, 1, 8'hA5, 5'b00001));
      vecs.push_back(mkv("n_clear", 0, 0, 5'b00000, z, 0, 8'h00, 5'b00000));
      vecs.push_back(mkv("rst2",    1, 0, 5'b00000, z, 0, 8'h00, 5'b11111));
      vecs.push_back(mkv("all_strb",0, 0, 5'b11111, mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 0, 8'h00, 5'b00000));
      vecs.push_back(mkv("all_w1",  0, 0, 5'b00000, z, 1, 8'h01, 5'b11111));
      vecs.push_back(mkv("all_w2",  0, 0, 5'b00000, z, 1, 8'h02, 5'b11110));
      vecs.push_back(mkv("all_w3",  0, 0, 5'b00000, z, 1, 8'h03, 5'b11100));
      vecs.push_back(mkv("all_w4",  0, 0, 5'b00000, z, 1, 8'h04, 5'b11000));
      vecs.push_back(mkv("all_w5",  0, 0, 5'b00000, z, 1, 8'h05, 5'b10000));
      vecs.push_back(mkv("all_done",0, 0, 5'b00000, z, 0, 8'h00, 5'b00000));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].full, vecs[i].ena, vecs[i].items);
         checkOutput(vecs[i].name, vecs[i].exp_write, vecs[i].exp_item, vecs[i].exp_busy, 1'b1);
      end

      sb_on = 1'b1;

      // Round-robin resume: pointer sits at S, so W beats N.
      step("rr_rst",  1, 0, 5'b00000, z, 0, 5'b11111);
      sbq.push_back(8'h99);
      step("rr_n1",   0, 0, 5'b00001, mk(8'h99, 0, 0, 0, 0), 0, 5'b00000);
      step("rr_n1wr", 0, 0, 5'b00000, z, 1, 5'b00001);
      sbq.push_back(8'h40);
      sbq.push_back(8'h10);
      step("rr_nw",   0, 0, 5'b01001, mk(8'h10, 0, 0, 8'h40, 0), 0, 5'b00000);
      step("rr_w_wr", 0, 0, 5'b00000, z, 1, 5'b01001);
      step("rr_n_wr", 0, 0, 5'b00000, z, 1, 5'b00001);
      step("rr_idle", 0, 0, 5'b00000, z, 0, 5'b00000);

      // Backpressure: second strobe into an occupied slot is ignored.
      sbq.push_back(8'h3C);
      step("bp_e1",    0, 1, 5'b00100, mk(0, 0, 8'h3C, 0, 0), 0, 5'b00000);
      step("bp_e2",    0, 1, 5'b00100, mk(0, 0, 8'hFF, 0, 0), 0, 5'b00100);
      step("bp_hold",  0, 1, 5'b00000, z, 0, 5'b00100);
      step("bp_drain", 0, 0, 5'b00000, z, 1, 5'b00100);
      step("bp_done",  0, 0, 5'b00000, z, 0, 5'b00000);
      step("bp_idle",  0, 0, 5'b00000, z, 0, 5'b00000);

      // Reset while N and L are held behind a full FIFO discards both.
      step("mr_fill", 0, 1, 5'b10001, mk(8'hAA, 0, 0, 0, 8'hBB), 0, 5'b00000);
      step("mr_held", 0, 1, 5'b00000, z, 0, 5'b10001);
      step("mr_rst",  1, 1, 5'b00000, z, 0, 5'b11111);
      step("mr_rel",  0, 0, 5'b00000, z, 0, 5'b00000);
      sbq.push_back(8'h77);
      step("mr_s",    0, 0, 5'b00010, mk(0, 8'h77, 0, 0, 0), 0, 5'b00000);
      step("mr_s_wr", 0, 0, 5'b00000, z, 1, 5'b00010);
      step("mr_idle0",0, 0, 5'b00000, z, 0, 5'b00000);
      step("mr_idle1",0, 0, 5'b00000, z, 0, 5'b00000);

      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL sb_drain: got %0d items never written want 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
